hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 84 ++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage forwarding select, load-use/WB stall, branch flush and debug halt/step control.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_branch,
  input  logic        br_eq,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_reg_write,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_reg_write,
  input  logic [4:0]  MEM_WB_rd,
  input  logic        MEM_WB_reg_write,
  input  logic        dbg_halt,
  input  logic        dbg_step,
  input  logic        cnt_clr,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        pc_sel,
  output logic        IF_flush,
  output logic        ctrl_sel,
  output logic [1:0]  forward_comp1,
  output logic [1:0]  forward_comp2,
  output logic        dbg_halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
  state_t      r_state;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        w_ex1, w_ex2, w_mem1, w_mem2, w_wb1, w_wb2;
  logic        w_hz_ld, w_hz_wb, w_stall, w_active, w_adv, w_flush;
  logic [1:0]  w_fc1, w_fc2;

  assign w_ex1  = ID_EX_reg_write  & (ID_EX_rd  != 5'd0) & id_use_rs1 & (ID_EX_rd  == IF_ID_rs1);
  assign w_ex2  = ID_EX_reg_write  & (ID_EX_rd  != 5'd0) & id_use_rs2 & (ID_EX_rd  == IF_ID_rs2);
  assign w_mem1 = EX_MEM_reg_write & (EX_MEM_rd != 5'd0) & id_use_rs1 & (EX_MEM_rd == IF_ID_rs1);
  assign w_mem2 = EX_MEM_reg_write & (EX_MEM_rd != 5'd0) & id_use_rs2 & (EX_MEM_rd == IF_ID_rs2);
  assign w_wb1  = MEM_WB_reg_write & (MEM_WB_rd != 5'd0) & id_use_rs1 & (MEM_WB_rd == IF_ID_rs1);
  assign w_wb2  = MEM_WB_reg_write & (MEM_WB_rd != 5'd0) & id_use_rs2 & (MEM_WB_rd == IF_ID_rs2);

  assign w_fc1 = (w_ex1 & ~ID_EX_mem_read) ? 2'b01 : w_mem1 ? 2'b10 : 2'b00;
  assign w_fc2 = (w_ex2 & ~ID_EX_mem_read) ? 2'b01 : w_mem2 ? 2'b10 : 2'b00;

  // A WB-only producer stalls because the regfile write is not visible to the same-cycle read.
  assign w_hz_ld  = (w_ex1 | w_ex2) & ID_EX_mem_read;
  assign w_hz_wb  = (w_wb1 & ~w_ex1 & ~w_mem1) | (w_wb2 & ~w_ex2 & ~w_mem2);
  assign w_stall  = w_hz_ld | w_hz_wb;
  assign w_active = r_state != HALT;
  assign w_adv    = w_active & ~w_stall;
  assign w_flush  = w_adv & id_branch & br_eq;

  assign pc_write      = reset_n & w_adv;
  assign IF_ID_write   = reset_n & w_adv;
  assign ctrl_sel      = reset_n & w_adv;
  assign pc_sel        = reset_n & w_flush;
  assign IF_flush      = reset_n & w_flush;
  assign forward_comp1 = reset_n ? w_fc1 : 2'b00;
  assign forward_comp2 = reset_n ? w_fc2 : 2'b00;
  assign dbg_halted    = reset_n & (r_state == HALT);
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN:     r_state <= dbg_halt ? HALT : RUN;
        HALT:    r_state <= !dbg_halt ? RUN : dbg_step ? STEP : HALT;
        STEP:    r_state <= !dbg_halt ? RUN : w_adv ? HALT : STEP;
        default: r_state <= RUN;
      endcase
      r_stall_cnt <= cnt_clr ? '0 : (w_stall & w_active & ~&r_stall_cnt) ? r_stall_cnt + 16'd1 : r_stall_cnt;
      r_flush_cnt <= cnt_clr ? '0 : (w_flush & ~&r_flush_cnt) ? r_flush_cnt + 16'd1 : r_flush_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a rule-level reference model checked every cycle.
module tb_hazard_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic id_use_rs1, id_use_rs2, id_branch, br_eq;
  logic ID_EX_reg_write, ID_EX_mem_read, EX_MEM_reg_write, MEM_WB_reg_write;
  logic dbg_halt, dbg_step, cnt_clr;
  logic pc_write, IF_ID_write, pc_sel, IF_flush, ctrl_sel, dbg_halted;
  logic [1:0] forward_comp1, forward_comp2;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  int m_mode = 0;
  int m_stall = 0, m_flush = 0;

  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch), .br_eq(br_eq),
    .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write(MEM_WB_reg_write),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .pc_sel(pc_sel), .IF_flush(IF_flush),
    .ctrl_sel(ctrl_sel), .forward_comp1(forward_comp1), .forward_comp2(forward_comp2),
    .dbg_halted(dbg_halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operand depends on a stage if that stage writes the nonzero register it reads.
  function automatic bit dep(input logic rw, input logic [4:0] rd, input logic [4:0] rs, input logic u);
    return u && rw && rs != 0 && rd == rs;
  endfunction
  function automatic int fwd(input logic [4:0] rs, input logic u);
    if (dep(ID_EX_reg_write, ID_EX_rd, rs, u) && !ID_EX_mem_read) return 1;
    if (dep(EX_MEM_reg_write, EX_MEM_rd, rs, u)) return 2;
    return 0;
  endfunction
  function automatic bit wb_only(input logic [4:0] rs, input logic u);
    return dep(MEM_WB_reg_write, MEM_WB_rd, rs, u) && !dep(ID_EX_reg_write, ID_EX_rd, rs, u)
           && !dep(EX_MEM_reg_write, EX_MEM_rd, rs, u);
  endfunction
  function automatic bit stall_now();
    bit ld;
    ld = ID_EX_mem_read && (dep(ID_EX_reg_write, ID_EX_rd, IF_ID_rs1, id_use_rs1) ||
                            dep(ID_EX_reg_write, ID_EX_rd, IF_ID_rs2, id_use_rs2));
    return ld || wb_only(IF_ID_rs1, id_use_rs1) || wb_only(IF_ID_rs2, id_use_rs2);
  endfunction
  function automatic bit adv_now();
    return m_mode != 1 && !stall_now();
  endfunction

  // mode: 0 running, 1 halted, 2 single-stepping
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (cnt_clr) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (stall_now() && m_mode != 1) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (adv_now() && id_branch && br_eq) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      end
      if (m_mode == 0) m_mode = dbg_halt ? 1 : 0;
      else if (m_mode == 1) m_mode = !dbg_halt ? 0 : (dbg_step ? 2 : 1);
      else m_mode = !dbg_halt ? 0 : (adv_now() ? 1 : 2);
    end
  end

  always @(negedge clk) begin
    int a, f;
    a = reset_n && adv_now();
    f = a && id_branch && br_eq;
    chk("pc_write", pc_write, a);
    chk("IF_ID_write", IF_ID_write, a);
    chk("ctrl_sel", ctrl_sel, a);
    chk("pc_sel", pc_sel, f);
    chk("IF_flush", IF_flush, f);
    chk("fc1", forward_comp1, reset_n ? fwd(IF_ID_rs1, id_use_rs1) : 0);
    chk("fc2", forward_comp2, reset_n ? fwd(IF_ID_rs2, id_use_rs2) : 0);
    chk("dbg_halted", dbg_halted, reset_n && m_mode == 1);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  end

  task automatic idle();
    IF_ID_rs1 = 0; IF_ID_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_branch = 0; br_eq = 0;
    ID_EX_rd = 0; ID_EX_reg_write = 0; ID_EX_mem_read = 0;
    EX_MEM_rd = 0; EX_MEM_reg_write = 0; MEM_WB_rd = 0; MEM_WB_reg_write = 0; cnt_clr = 0;
  endtask
  task automatic load_use();
    idle();
    ID_EX_mem_read = 1; ID_EX_reg_write = 1; ID_EX_rd = 5; IF_ID_rs1 = 5; id_use_rs1 = 1;
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    idle(); dbg_halt = 0; dbg_step = 0;
    ID_EX_reg_write = 1; ID_EX_rd = 7; IF_ID_rs2 = 7; id_use_rs2 = 1;
    @(negedge clk);
    chk("rst_fc2", forward_comp2, 0);
    chk("rst_pc_write", pc_write, 0);
    nxt(); reset_n = 1; idle();
    nxt();
    load_use();
    @(negedge clk);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ctrl_sel", ctrl_sel, 0);
    nxt(); idle(); EX_MEM_reg_write = 1; EX_MEM_rd = 5; IF_ID_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_fc1_mem", forward_comp1, 2);
    chk("lu_adv", pc_write, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    nxt(); idle();
    ID_EX_reg_write = 1; ID_EX_rd = 7; EX_MEM_reg_write = 1; EX_MEM_rd = 7; IF_ID_rs2 = 7; id_use_rs2 = 1;
    @(negedge clk);
    chk("prio_fc2", forward_comp2, 1);
    nxt(); ID_EX_rd = 0; EX_MEM_rd = 0; IF_ID_rs2 = 0;
    @(negedge clk);
    chk("r0_fc2", forward_comp2, 0);
    chk("r0_adv", pc_write, 1);
    nxt(); idle(); MEM_WB_reg_write = 1; MEM_WB_rd = 3; IF_ID_rs1 = 3; id_use_rs1 = 1;
    @(negedge clk);
    chk("wb_stall", pc_write, 0);
    nxt(); MEM_WB_reg_write = 0;
    @(negedge clk);
    chk("wb_fc1", forward_comp1, 0);
    chk("wb_adv", pc_write, 1);
    chk("wb_stall_cnt", stall_cnt, 2);
    nxt(); idle(); id_branch = 1; br_eq = 1;
    @(negedge clk);
    chk("br_pc_sel", pc_sel, 1);
    chk("br_flush", IF_flush, 1);
    nxt(); idle();
    @(negedge clk);
    chk("br_flush_cnt", flush_cnt, 1);
    nxt(); load_use(); id_branch = 1; br_eq = 1;
    @(negedge clk);
    chk("br_ld_flush", IF_flush, 0);
    nxt(); idle(); dbg_halt = 1;
    @(negedge clk);
    chk("halt_req_adv", pc_write, 1);
    nxt(); ID_EX_reg_write = 1; ID_EX_rd = 9; IF_ID_rs1 = 9; id_use_rs1 = 1;
    @(negedge clk);
    chk("halted", dbg_halted, 1);
    chk("halt_pc_write", pc_write, 0);
    chk("halt_fc1", forward_comp1, 1);
    nxt(); idle(); dbg_step = 1;
    @(negedge clk);
    chk("halt_step_req", pc_write, 0);
    nxt(); dbg_step = 0;
    @(negedge clk);
    chk("step_adv", pc_write, 1);
    chk("step_halted", dbg_halted, 0);
    nxt();
    @(negedge clk);
    chk("step_rehalt", dbg_halted, 1);
    dbg_step = 1;
    nxt(); dbg_step = 0; load_use();
    @(negedge clk);
    chk("step_stall", pc_write, 0);
    nxt(); idle();
    @(negedge clk);
    chk("step_stall_adv", pc_write, 1);
    nxt();
    @(negedge clk);
    chk("step_stall_halt", dbg_halted, 1);
    dbg_halt = 0;
    nxt();
    @(negedge clk);
    chk("resume", dbg_halted, 0);
    chk("resume_adv", pc_write, 1);
    cnt_clr = 1;
    nxt(); load_use();
    repeat (65537) nxt();
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    cnt_clr = 1;
    nxt(); cnt_clr = 0;
    @(negedge clk);
    chk("clr_stall_cnt", stall_cnt, 0);
    dbg_halt = 1;
    nxt(); dbg_step = 1;
    nxt(); dbg_step = 0; EX_MEM_reg_write = 1; EX_MEM_rd = 4; IF_ID_rs2 = 4; id_use_rs2 = 1;
    nxt(); #2 reset_n = 0; #1;
    chk("rst_step_pc_write", pc_write, 0);
    chk("rst_step_fc2", forward_comp2, 0);
    chk("rst_step_cnt", stall_cnt, 0);
    chk("rst_step_halted", dbg_halted, 0);
    nxt(); dbg_halt = 0; idle(); reset_n = 1;
    @(negedge clk);
    chk("rst_run", pc_write, 1);
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
